// File: rtl/cve2_pkg.sv
// rtl/cve2_pkg.sv - shared core types: ALU operator encoding and MAC sequencer states
package cve2_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_XOR = 4'd2,
        ALU_OR  = 4'd3,
        ALU_AND = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_MAC = 4'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        MAC_IDLE = 3'd0,
        MAC_LL   = 3'd1,
        MAC_HL   = 3'd2,
        MAC_LH   = 3'd3,
        MAC_DONE = 3'd4
    } mac_state_e;

endpackage

// File: rtl/cve2_mac_mul16.sv
// rtl/cve2_mac_mul16.sv - combinational 16x16 -> 32 unsigned multiplier shared by all MAC steps
module cve2_mac_mul16 (
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic [31:0] prod
);

    // Full-width unsigned product; 32 bits can never overflow for 16x16
    always_comb begin
        prod = 32'(op_a) * 32'(op_b);
    end

endmodule

// File: rtl/cve2_mac_seq.sv
// rtl/cve2_mac_seq.sv - multi-cycle (a*b)+acc sequencer built on one shared 16x16 multiplier
module cve2_mac_seq
    import cve2_pkg::*;
#(
    parameter bit EarlyOut = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  alu_op_e     alu_operator_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [31:0] acc_i,
    input  logic        kill_i,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        busy_o
);

    mac_state_e  state_q, state_d;
    logic [31:0] a_q, b_q, acc_q, result_q;
    logic [15:0] mul_a, mul_b;
    logic [31:0] prod, addend, sum;
    logic        accept, computing, a_hi_zero, b_hi_zero;

    assign accept    = valid_i && (state_q == MAC_IDLE) && (alu_operator_i == ALU_MAC) && !kill_i;
    assign computing = (state_q == MAC_LL) || (state_q == MAC_HL) || (state_q == MAC_LH);
    assign a_hi_zero = (a_q[31:16] == 16'h0);
    assign b_hi_zero = (b_q[31:16] == 16'h0);

    // Select the operand halves for the partial product of the current step
    always_comb begin
        mul_a = 16'h0;
        mul_b = 16'h0;
        case (state_q)
            MAC_LL: begin mul_a = a_q[15:0];  mul_b = b_q[15:0];  end
            MAC_HL: begin mul_a = a_q[31:16]; mul_b = b_q[15:0];  end
            MAC_LH: begin mul_a = a_q[15:0];  mul_b = b_q[31:16]; end
            default: begin mul_a = 16'h0;     mul_b = 16'h0;      end
        endcase
    end

    cve2_mac_mul16 u_mul16 (
        .op_a (mul_a),
        .op_b (mul_b),
        .prod (prod)
    );

    // Cross terms land 16 bits up; anything beyond bit 31 is dropped
    always_comb begin
        addend = (state_q == MAC_LL) ? prod : {prod[15:0], 16'h0};
        sum    = acc_q + addend;
    end

    // Next-state logic; a flush during any compute step abandons the sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            MAC_IDLE: if (accept) state_d = MAC_LL;
            MAC_LL: begin
                if (EarlyOut && a_hi_zero) state_d = (b_hi_zero) ? MAC_DONE : MAC_LH;
                else                       state_d = MAC_HL;
            end
            MAC_HL:   state_d = (EarlyOut && b_hi_zero) ? MAC_DONE : MAC_LH;
            MAC_LH:   state_d = MAC_DONE;
            MAC_DONE: state_d = MAC_IDLE;
            default:  state_d = MAC_IDLE;
        endcase
        if (kill_i && computing) state_d = MAC_IDLE;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= MAC_IDLE;
        else       state_q <= state_d;
    end

    // Operands captured once at acceptance; accumulator seeded then updated per step
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q   <= 32'h0;
            b_q   <= 32'h0;
            acc_q <= 32'h0;
        end else if (accept) begin
            a_q   <= op_a_i;
            b_q   <= op_b_i;
            acc_q <= acc_i;
        end else if (computing) begin
            acc_q <= sum;
        end
    end

    // Result loads only on the edge entering DONE, so kills leave it untouched
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                       result_q <= 32'h0;
        else if (state_d == MAC_DONE && state_q != MAC_DONE) result_q <= sum;
    end

    assign ready_o  = (state_q == MAC_IDLE);
    assign busy_o   = (state_q != MAC_IDLE);
    assign valid_o  = (state_q == MAC_DONE);
    assign result_o = result_q;

endmodule

// File: doc/cve2_mac_seq.md
# cve2_mac_seq

Multi-cycle sequencer for the core's MAC operation. It computes `(op_a * op_b) + acc`, modulo 2^32, by iterating over 16x16 partial products on one shared 16-bit multiplier instead of a full 32x32 array. It sits beside the ALU in the execute stage: the ID/EX control issues a MAC through a valid/ready handshake and receives a one-cycle result strobe.

## Interface
- `EarlyOut`, default `1'b0`: when 1, skip a partial-product step whose upper operand half is zero.
- `clk_i  in  1`: clock.
- `rst_i  in  1`: reset, asynchronous, active-high.
- `alu_operator_i  in  cve2_pkg::alu_op_e`: operation select; only `ALU_MAC` starts a sequence.
- `valid_i  in  1`: request valid.
- `ready_o  out  1`: accepting requests; high only in IDLE.
- `op_a_i  in  32`: multiplicand, unsigned.
- `op_b_i  in  32`: multiplier, unsigned.
- `acc_i  in  32`: accumulator addend.
- `kill_i  in  1`: abort the current or starting operation (flush).
- `valid_o  out  1`: result strobe, high for exactly one cycle.
- `result_o  out  32`: result; holds its last value between strobes.
- `busy_o  out  1`: high when the state is not IDLE.

## Operation
- States: IDLE, LL, HL, LH, DONE.
- Accept when `valid_i && ready_o && alu_operator_i == ALU_MAC && !kill_i`:
  - register `op_a_i` and `op_b_i`;
  - load the 32-bit accumulator register with `acc_i`;
  - go to LL.
- `valid_i` with any other operator: ignored; stay in IDLE; no strobe.
- LL: `acc += a[15:0]*b[15:0]`; go to HL.
- HL: `acc += (a[31:16]*b[15:0]) << 16`; go to LH.
- LH: `acc += (a[15:0]*b[31:16]) << 16`; go to DONE.
- Term `a[31:16]*b[31:16]` only affects bits ≥32 and is never computed.
- Arithmetic:
  - partial products are 32-bit unsigned;
  - the shifted terms keep bits [31:0] only;
  - all additions wrap modulo 2^32.
- DONE: `valid_o = 1`; `result_o` is loaded from `acc` on the DONE-entry edge; go to IDLE.
- `EarlyOut = 1`:
  - from LL, skip HL if `a[31:16] == 0`;
  - skip LH if `b[31:16] == 0`;
  - skipped steps go straight to the next remaining step or DONE.
- `kill_i`:
  - in LL, HL or LH: go to IDLE at the next edge; no strobe; `result_o` unchanged;
  - in IDLE together with `valid_i`: request not accepted;
  - in DONE: no effect, the strobe still occurs.
- Reset values:
  - state IDLE;
  - `ready_o = 1`, `valid_o = 0`, `busy_o = 0`;
  - `result_o = 0`;
  - operand and accumulator registers = 0.
- Reset mid-sequence returns to IDLE immediately (asynchronous); no strobe follows.

## Timing
- Accept at edge E0. With `EarlyOut = 0`:
  - LL in cycle 1, HL in cycle 2, LH in cycle 3;
  - DONE in cycle 4: `valid_o` high, `result_o` valid.
- With `EarlyOut = 1`, latency is 2, 3 or 4 cycles depending on the zero upper halves.
- `ready_o` is low from cycle 1 through the DONE cycle and high again the cycle after DONE.
- Back-to-back throughput: one MAC per 5 cycles (fixed mode).
- `ready_o`, `valid_o` and `busy_o` decode from the state register only; there is no combinational path from any input.
- Operands are sampled only at acceptance; input changes during a sequence are ignored.

## Structure
- `cve2_pkg`:
  - add `mac_state_e` (IDLE, LL, HL, LH, DONE);
  - `ALU_MAC` already exists in `alu_op_e`.
- Sub-module `cve2_mac_mul16`: combinational 16x16 → 32 unsigned multiplier. Operand halves are muxed into it by state.
- Top level holds the FSM, the operand registers, the accumulator/adder and the `result_o` register.

## Test plan
- a=3, b=5, acc=7, `EarlyOut=0` → `valid_o` in cycle 4, `result_o=22`; `ready_o` high in cycle 5.
- a=0xFFFFFFFF, b=0xFFFFFFFF, acc=0 → `result_o=0x00000001`.
- a=0x00010000, b=0x00010000, acc=0x12345678 → `result_o=0x12345678` (product wraps to 0).
- Start a MAC producing 22, then `kill_i` in HL → no `valid_o`, IDLE next cycle, `result_o` stays at the prior value; `valid_i` with a non-MAC operator → no strobe, `busy_o=0`.
- `EarlyOut=1`:
  - a=3, b=5 → strobe in cycle 2;
  - a=0x00020003, b=5, acc=1 → strobe in cycle 3, `result_o=0x000A0010`.
- Assert `rst_i` in LH → all outputs at reset values immediately; no strobe afterwards; the next MAC completes correctly.
